ovl_frame_mc: RTL and testbench

Multi-channel, parametrised frame checker: the next generation of the single-channel OVL frame assertion. Each of `NUM_CH` independent channels watches a `start_event` rising edge and checks that `test_expr` stays low for `MIN_CKS` cycles, then goes high by `MAX_CKS` cycles. Violations are reported as registered per-channel fire vectors, and a shared saturating error counter accumulates them. The block sits beside the OVL library checkers in directed benches and in RTL as a bound assertion.

---
 rtl/ovl_frame_mc.sv | 181 ++++++++++++++++++
 tb/tb_ovl_frame_mc.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ovl_frame_mc.sv
// ovl_frame_mc: multi-channel start-to-response frame checker.
// Each channel arms on a rising edge of start_event[ch]. It then requires
// test_expr[ch] to stay low for MIN_CKS cycles and to rise by MAX_CKS cycles.
// Violations pulse registered per-channel fire bits. A shared saturating
// counter accumulates every fire bit that is set.
//
// Ports:
//   clock          rising-edge clock
//   reset          synchronous, active-low reset
//   enable         global check enable (low: hold windows, drop edges, no fires)
//   start_event    per-channel start qualifier (rising edge detected)
//   test_expr      per-channel response
//   window_active  channel has an open window (mirrors OPEN state)
//   fire_min       response arrived before MIN_CKS (one-cycle pulse)
//   fire_max       no response by MAX_CKS (one-cycle pulse)
//   fire_new_start start edge while a window is open, mode 2 only (pulse)
//   fire_any       OR of all fire bits, same cycle as the fire vectors
//   err_count      saturating total of asserted fire bits
module ovl_frame_mc #(
    parameter int unsigned NUM_CH         = 1,
    parameter int unsigned MIN_CKS        = 1,
    parameter int unsigned MAX_CKS        = 2,
    parameter int unsigned NEW_START_MODE = 0,
    parameter int unsigned ERR_W          = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] start_event,
    input  logic [NUM_CH-1:0] test_expr,
    output logic [NUM_CH-1:0] window_active,
    output logic [NUM_CH-1:0] fire_min,
    output logic [NUM_CH-1:0] fire_max,
    output logic [NUM_CH-1:0] fire_new_start,
    output logic              fire_any,
    output logic [ERR_W-1:0]  err_count
);

    localparam int unsigned SPAN   = (MIN_CKS > MAX_CKS) ? MIN_CKS : MAX_CKS;
    localparam int unsigned DW     = (SPAN < 1) ? 1 : $clog2(SPAN + 1);
    localparam int unsigned PW     = $clog2(3 * NUM_CH + 1);
    localparam int unsigned SW     = ((ERR_W > PW) ? ERR_W : PW) + 1;
    localparam bit          CHK_ON = (MIN_CKS != 0) || (MAX_CKS != 0);
    localparam logic [DW-1:0]    D_SAT   = '1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    // Parameter sanity checks at elaboration
    if (MAX_CKS != 0 && MAX_CKS < MIN_CKS) begin : g_bad_window
        $error("ovl_frame_mc: MAX_CKS (%0d) < MIN_CKS (%0d)", MAX_CKS, MIN_CKS);
    end
    if (NEW_START_MODE > 2) begin : g_bad_mode
        $error("ovl_frame_mc: NEW_START_MODE (%0d) must be 0, 1 or 2", NEW_START_MODE);
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OPEN = 1'b1
    } state_t;

    state_t            state_q [NUM_CH];
    state_t            state_d [NUM_CH];
    logic [DW-1:0]     d_q     [NUM_CH];
    logic [DW-1:0]     d_d     [NUM_CH];
    logic [NUM_CH-1:0] start_prev_q;

    logic [NUM_CH-1:0] window_active_d;
    logic [NUM_CH-1:0] fire_min_d;
    logic [NUM_CH-1:0] fire_max_d;
    logic [NUM_CH-1:0] fire_new_start_d;
    logic              fire_any_d;
    logic [ERR_W-1:0]  err_count_d;

    // Per-channel window evaluation and error accumulation
    always_comb begin
        logic          st_edge;
        logic          eval;
        logic [DW-1:0] d_ev;
        logic [PW-1:0] pop;
        logic [SW-1:0] sum;

        st_edge          = 1'b0;
        eval             = 1'b0;
        d_ev             = '0;
        pop              = '0;
        sum              = '0;
        fire_min_d       = '0;
        fire_max_d       = '0;
        fire_new_start_d = '0;
        window_active_d  = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            state_d[ch] = state_q[ch];
            d_d[ch]     = d_q[ch];
        end

        for (int ch = 0; ch < NUM_CH; ch++) begin
            st_edge = start_event[ch] & ~start_prev_q[ch];
            eval    = 1'b0;
            d_ev    = d_q[ch];

            // Decide whether this cycle samples the response, and at which d
            if (CHK_ON && enable) begin
                if (state_q[ch] == ST_IDLE) begin
                    if (st_edge) begin
                        eval = 1'b1;
                        d_ev = '0;
                    end
                end else begin
                    eval = 1'b1;
                    if (st_edge) begin
                        if (NEW_START_MODE == 1) begin
                            d_ev = '0;
                        end else if (NEW_START_MODE == 2) begin
                            fire_new_start_d[ch] = 1'b1;
                        end
                    end
                end
            end

            if (eval) begin
                if (test_expr[ch]) begin
                    // Response closes the window; early response is a min violation
                    state_d[ch] = ST_IDLE;
                    if ((32'(d_ev) + 32'd1) <= MIN_CKS) begin
                        fire_min_d[ch] = 1'b1;
                    end
                end else if ((MAX_CKS != 0) && (32'(d_ev) == MAX_CKS)) begin
                    state_d[ch]    = ST_IDLE;
                    fire_max_d[ch] = 1'b1;
                end else begin
                    // Still waiting; d saturates only matters when MAX_CKS is 0
                    state_d[ch] = ST_OPEN;
                    d_d[ch]     = (d_ev == D_SAT) ? d_ev : d_ev + DW'(1);
                end
            end

            window_active_d[ch] = (state_d[ch] == ST_OPEN);
            pop = pop + PW'(fire_min_d[ch]) + PW'(fire_max_d[ch])
                      + PW'(fire_new_start_d[ch]);
        end

        fire_any_d = |{fire_min_d, fire_max_d, fire_new_start_d};

        // Saturating add: any carry above ERR_W bits clamps to all-ones
        sum = SW'(err_count) + SW'(pop);
        if (sum[SW-1:ERR_W] != '0) begin
            err_count_d = ERR_MAX;
        end else begin
            err_count_d = sum[ERR_W-1:0];
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch] <= ST_IDLE;
                d_q[ch]     <= '0;
            end
            start_prev_q   <= '0;
            window_active  <= '0;
            fire_min       <= '0;
            fire_max       <= '0;
            fire_new_start <= '0;
            fire_any       <= 1'b0;
            err_count      <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch] <= state_d[ch];
                d_q[ch]     <= d_d[ch];
            end
            start_prev_q   <= start_event;
            window_active  <= window_active_d;
            fire_min       <= fire_min_d;
            fire_max       <= fire_max_d;
            fire_new_start <= fire_new_start_d;
            fire_any       <= fire_any_d;
            err_count      <= err_count_d;
        end
    end

endmodule

// File: tb/tb_ovl_frame_mc.sv
// Directed bench for ovl_frame_mc: five instances (modes 0/1/2, 2-bit counter,
// checks disabled) share one stimulus; each scenario checks the relevant one.
module tb_ovl_frame_mc;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] start_event;
    logic [1:0] test_expr;

    always #5 clock = ~clock;

    logic [1:0]  m0_wa, m0_fmin, m0_fmax, m0_fns;
    logic        m0_fany;
    logic [15:0] m0_err;
    logic [1:0]  m1_wa, m1_fmin, m1_fmax, m1_fns;
    logic        m1_fany;
    logic [15:0] m1_err;
    logic [1:0]  m2_wa, m2_fmin, m2_fmax, m2_fns;
    logic        m2_fany;
    logic [15:0] m2_err;
    logic [1:0]  sat_wa, sat_fmin, sat_fmax, sat_fns;
    logic        sat_fany;
    logic [1:0]  sat_err;
    logic [1:0]  dis_wa, dis_fmin, dis_fmax, dis_fns;
    logic        dis_fany;
    logic [15:0] dis_err;

    ovl_frame_mc #(.NUM_CH(2), .MIN_CKS(2), .MAX_CKS(4), .NEW_START_MODE(0), .ERR_W(16)) u_m0 (
        .clock(clock), .reset(reset), .enable(enable), .start_event(start_event),
        .test_expr(test_expr), .window_active(m0_wa), .fire_min(m0_fmin), .fire_max(m0_fmax),
        .fire_new_start(m0_fns), .fire_any(m0_fany), .err_count(m0_err));

    ovl_frame_mc #(.NUM_CH(2), .MIN_CKS(2), .MAX_CKS(4), .NEW_START_MODE(1), .ERR_W(16)) u_m1 (
        .clock(clock), .reset(reset), .enable(enable), .start_event(start_event),
        .test_expr(test_expr), .window_active(m1_wa), .fire_min(m1_fmin), .fire_max(m1_fmax),
        .fire_new_start(m1_fns), .fire_any(m1_fany), .err_count(m1_err));

    ovl_frame_mc #(.NUM_CH(2), .MIN_CKS(2), .MAX_CKS(4), .NEW_START_MODE(2), .ERR_W(16)) u_m2 (
        .clock(clock), .reset(reset), .enable(enable), .start_event(start_event),
        .test_expr(test_expr), .window_active(m2_wa), .fire_min(m2_fmin), .fire_max(m2_fmax),
        .fire_new_start(m2_fns), .fire_any(m2_fany), .err_count(m2_err));

    ovl_frame_mc #(.NUM_CH(2), .MIN_CKS(2), .MAX_CKS(4), .NEW_START_MODE(0), .ERR_W(2)) u_sat (
        .clock(clock), .reset(reset), .enable(enable), .start_event(start_event),
        .test_expr(test_expr), .window_active(sat_wa), .fire_min(sat_fmin), .fire_max(sat_fmax),
        .fire_new_start(sat_fns), .fire_any(sat_fany), .err_count(sat_err));

    ovl_frame_mc #(.NUM_CH(2), .MIN_CKS(0), .MAX_CKS(0), .NEW_START_MODE(0), .ERR_W(16)) u_dis (
        .clock(clock), .reset(reset), .enable(enable), .start_event(start_event),
        .test_expr(test_expr), .window_active(dis_wa), .fire_min(dis_fmin), .fire_max(dis_fmax),
        .fire_new_start(dis_fns), .fire_any(dis_fany), .err_count(dis_err));

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic dis_seen = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Advance one cycle; outputs are then stable for cycle 'cyc'
    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input logic [1:0] st);
        reset       = 1'b0;
        enable      = 1'b1;
        start_event = st;
        test_expr   = 2'b00;
        tick();
        reset = 1'b1;
        cyc   = 0;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    // The checks-disabled instance must never assert anything
    always @(negedge clock) begin
        if ((|{dis_wa, dis_fmin, dis_fmax, dis_fns, dis_fany, dis_err}) === 1'b1) dis_seen = 1'b1;
    end

    initial begin
        logic seen;
        reset       = 1'b0;
        enable      = 1'b1;
        start_event = 2'b00;
        test_expr   = 2'b00;

        // Reset state
        do_reset(2'b00);
        check("rst_wa", 32'(m0_wa), 32'd0);
        check("rst_fany", 32'(m0_fany), 32'd0);
        check("rst_err", 32'(m0_err), 32'd0);

        // Min violation on ch0 (d=1); zero-length min violation on ch1 (d=0)
        run_to(10);
        start_event = 2'b11;
        test_expr   = 2'b10;
        tick(); // 11
        check("A_fmin_zero_len", 32'(m0_fmin), 32'h2);
        check("A_wa11", 32'(m0_wa), 32'h1);
        check("A_err11", 32'(m0_err), 32'd1);
        test_expr = 2'b01;
        tick(); // 12
        check("A_fmin_ch0", 32'(m0_fmin), 32'h1);
        check("A_fany12", 32'(m0_fany), 32'd1);
        check("A_err12", 32'(m0_err), 32'd2);
        check("A_wa12", 32'(m0_wa), 32'h0);
        test_expr   = 2'b00;
        start_event = 2'b00;
        tick(); // 13
        check("A_fmin_pulse", 32'(m0_fmin), 32'h0);
        check("A_err13", 32'(m0_err), 32'd2);

        // Pass: ch1 responds at d=MIN (12), ch0 at d=3 (13)
        do_reset(2'b00);
        run_to(10);
        start_event = 2'b11;
        tick(); // 11
        check("B_wa11", 32'(m0_wa), 32'h3);
        tick(); // 12
        check("B_wa12", 32'(m0_wa), 32'h3);
        test_expr = 2'b10;
        tick(); // 13
        check("B_wa13", 32'(m0_wa), 32'h1);
        check("B_fmin13", 32'(m0_fmin), 32'h0);
        test_expr = 2'b01;
        tick(); // 14
        check("B_wa14", 32'(m0_wa), 32'h0);
        check("B_fany14", 32'(m0_fany), 32'd0);
        check("B_err14", 32'(m0_err), 32'd0);
        test_expr   = 2'b00;
        start_event = 2'b00;

        // Max violation on both channels in the same cycle
        do_reset(2'b00);
        run_to(10);
        start_event = 2'b11;
        run_to(14);
        check("C_wa14", 32'(m0_wa), 32'h3);
        check("C_fmax14", 32'(m0_fmax), 32'h0);
        tick(); // 15
        check("C_fmax15", 32'(m0_fmax), 32'h3);
        check("C_err15", 32'(m0_err), 32'd2);
        check("C_fany15", 32'(m0_fany), 32'd1);
        tick(); // 16
        check("C_fmax16", 32'(m0_fmax), 32'h0);
        check("C_wa16", 32'(m0_wa), 32'h0);
        start_event = 2'b00;

        // Second edge at 12 on ch0: modes 0/1/2 side by side
        do_reset(2'b00);
        run_to(10);
        start_event = 2'b01;
        tick(); // 11
        start_event = 2'b00;
        tick(); // 12
        start_event = 2'b01;
        tick(); // 13
        check("D_m2_fns13", 32'(m2_fns), 32'h1);
        check("D_m2_err13", 32'(m2_err), 32'd1);
        check("D_m1_fns13", 32'(m1_fns), 32'h0);
        check("D_m0_fns13", 32'(m0_fns), 32'h0);
        run_to(15);
        check("D_m0_fmax15", 32'(m0_fmax), 32'h1);
        check("D_m2_fmax15", 32'(m2_fmax), 32'h1);
        check("D_m2_err15", 32'(m2_err), 32'd2);
        check("D_m1_fmax15", 32'(m1_fmax), 32'h0);
        check("D_m1_wa15", 32'(m1_wa), 32'h1);
        tick(); // 16
        check("D_m1_wa16", 32'(m1_wa), 32'h1);
        test_expr = 2'b01;
        tick(); // 17
        check("D_m1_wa17", 32'(m1_wa), 32'h0);
        check("D_m1_fany17", 32'(m1_fany), 32'd0);
        check("D_m1_err17", 32'(m1_err), 32'd0);
        test_expr   = 2'b00;
        start_event = 2'b00;

        // Enable low on 11-12 shifts the max fire from 15 to 17
        do_reset(2'b00);
        run_to(10);
        start_event = 2'b01;
        tick(); // 11
        enable = 1'b0;
        tick(); // 12
        check("E_wa_hold12", 32'(m0_wa), 32'h1);
        tick(); // 13
        enable = 1'b1;
        run_to(16);
        check("E_fmax16", 32'(m0_fmax), 32'h0);
        tick(); // 17
        check("E_fmax17", 32'(m0_fmax), 32'h1);
        check("E_err17", 32'(m0_err), 32'd1);
        start_event = 2'b00;

        // Reset mid-window discards it silently
        do_reset(2'b00);
        run_to(10);
        start_event = 2'b01;
        run_to(12);
        reset       = 1'b0;
        start_event = 2'b00;
        tick(); // 13
        reset = 1'b1;
        check("F_wa13", 32'(m0_wa), 32'h0);
        check("F_err13", 32'(m0_err), 32'd0);
        seen = 1'b0;
        repeat (7) begin
            tick();
            seen = seen | m0_fany | (|m0_wa);
        end
        check("F_quiet", 32'(seen), 32'd0);

        // start_event held high through reset release is an edge in cycle 0
        do_reset(2'b01);
        tick(); // 1
        check("G_wa1", 32'(m0_wa), 32'h1);
        run_to(5);
        check("G_fmax5", 32'(m0_fmax), 32'h1);
        start_event = 2'b00;

        // Saturation: five zero-length min violations into a 2-bit counter
        do_reset(2'b00);
        run_to(2);
        start_event = 2'b11;
        test_expr   = 2'b11;
        tick();
        check("H_sat_first", 32'(sat_err), 32'd2);
        start_event = 2'b00;
        test_expr   = 2'b00;
        tick();
        start_event = 2'b11;
        test_expr   = 2'b11;
        tick();
        check("H_sat_clamp", 32'(sat_err), 32'd3);
        start_event = 2'b00;
        test_expr   = 2'b00;
        tick();
        start_event = 2'b01;
        test_expr   = 2'b01;
        tick();
        start_event = 2'b00;
        test_expr   = 2'b00;
        tick();
        check("H_sat_final", 32'(sat_err), 32'd3);
        check("H_wide_final", 32'(m0_err), 32'd5);

        // Checks disabled: nothing ever asserted on that instance
        check("dis_quiet", 32'(dis_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
